// File: rtl/led_matrix_scanner_if.sv
// LED matrix scanner bus: scan control and pixel frame in, plus the
// 74HC595-style chain controls, the row drive and the frame strobe out.
//   en, pixels          : scan enable and packed pixel intensities
//   rows_out            : one-hot row select, active high
//   ds/shcp/stcp        : serial data, shift clock, storage latch clock
//   mr_n/oe_n           : chain master reset and output enable, active low
//   frame_done          : one-clk pulse at end of each full frame
// master = scanner side, slave = matrix/board side.
interface led_matrix_scanner_if #(
   parameter int ROWS     = 8,
   parameter int COLS     = 8,
   parameter int CHANNELS = 2,
   parameter int BPP      = 2
);
   logic                               en;
   logic [ROWS*COLS*CHANNELS*BPP-1:0]  pixels;
   logic [ROWS-1:0]                    rows_out;
   logic                               ds;
   logic                               shcp;
   logic                               stcp;
   logic                               mr_n;
   logic                               oe_n;
   logic                               frame_done;

   modport master (
      input  en, pixels,
      output rows_out, ds, shcp, stcp, mr_n, oe_n, frame_done
   );

   modport slave (
      output en, pixels,
      input  rows_out, ds, shcp, stcp, mr_n, oe_n, frame_done
   );
endinterface

// File: rtl/led_matrix_scanner.sv
// Scans a ROWS x COLS matrix with CHANNELS colour planes per column through a
// shift-register chain, with threshold PWM of BPP bits per pixel. The pixel
// frame is snapshotted at the start of every frame, the chain is blanked while
// shifting, and all timing advances on a tick every DIV clocks.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : led_matrix_scanner_if master modport (en/pixels in, chain out)
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | stopped, divider held, mr_n released, waiting for en
// S_CLEAR   | one tick: chain reset, snapshot pixels, row=0 plane=1
// S_SHIFT   | 2 ticks per chain bit, bit k=N-1 first, outputs blanked
// S_LATCH   | one tick: stcp high, row select updated
// S_DISPLAY | ON_TICKS ticks with oe_n low, then advance plane/row
module led_matrix_scanner #(
   parameter int ROWS     = 8,
   parameter int COLS     = 8,
   parameter int CHANNELS = 2,
   parameter int BPP      = 2,
   parameter int DIV      = 128,
   parameter int ON_TICKS = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   led_matrix_scanner_if.master bus
);
   localparam int LEVELS  = (1 << BPP) - 1;
   localparam int N       = COLS * CHANNELS;
   localparam int FRAME_W = ROWS * N * BPP;
   localparam int ROW_W   = $clog2(ROWS);
   localparam int K_W     = (N > 1) ? $clog2(N) : 1;
   localparam int ON_W    = (ON_TICKS > 1) ? $clog2(ON_TICKS) : 1;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_LATCH, S_DISPLAY} state_t;

   state_t               state_q, state_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [ROW_W-1:0]     row_q, row_d, row_nx;
   logic [BPP-1:0]       plane_q, plane_d, plane_nx;
   logic [K_W-1:0]       k_q, k_d;
   logic                 phase_q, phase_d;
   logic [ON_W-1:0]      on_q, on_d;
   logic [FRAME_W-1:0]   snap_q, snap_d;
   logic [ROWS-1:0]      rows_q, rows_d;
   logic                 ds_q, ds_d, shcp_q, shcp_d, stcp_q, stcp_d;
   logic                 mr_n_q, mr_n_d, oe_n_q, oe_n_d, fd_q, fd_d;
   logic                 tick, last_row, last_plane;

   // Chain index k = ch*COLS+c, so (row*N + k) addresses the packed field
   // at ((row*CHANNELS+ch)*COLS+c)*BPP directly.
   function automatic logic pix_bit(input logic [FRAME_W-1:0] f,
                                    input logic [ROW_W-1:0]   r,
                                    input logic [K_W-1:0]     k,
                                    input logic [BPP-1:0]     p);
      logic [BPP-1:0] v;
      v = f[(int'(r) * N + int'(k)) * BPP +: BPP];
      return (v >= p);
   endfunction

   assign tick = (div_q == DIV_W'(DIV - 1));

   always_comb begin
      last_row   = (row_q == ROW_W'(ROWS - 1));
      last_plane = (plane_q == BPP'(LEVELS));
      plane_nx   = last_plane ? BPP'(1) : plane_q + 1'b1;
      row_nx     = row_q;
      if (last_plane) row_nx = last_row ? '0 : row_q + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      plane_d = plane_q;
      k_d     = k_q;
      phase_d = phase_q;
      on_d    = on_q;
      snap_d  = snap_q;
      rows_d  = rows_q;
      ds_d    = ds_q;
      shcp_d  = shcp_q;
      stcp_d  = stcp_q;
      mr_n_d  = mr_n_q;
      oe_n_d  = oe_n_q;
      fd_d    = 1'b0;

      // Divider only runs once there is something to time.
      if (state_q == S_IDLE && !bus.en) div_d = '0;
      else if (tick)                    div_d = '0;
      else                              div_d = div_q + 1'b1;

      if (state_q == S_IDLE) mr_n_d = 1'b1;

      if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (bus.en) begin
                  state_d = S_CLEAR;
                  mr_n_d  = 1'b0;
                  oe_n_d  = 1'b1;
                  ds_d    = 1'b0;
                  snap_d  = bus.pixels;
                  row_d   = '0;
                  plane_d = BPP'(1);
               end
            end
            S_CLEAR: begin
               state_d = S_SHIFT;
               mr_n_d  = 1'b1;
               k_d     = K_W'(N - 1);
               phase_d = 1'b0;
               shcp_d  = 1'b0;
               ds_d    = pix_bit(snap_q, row_q, K_W'(N - 1), plane_q);
            end
            S_SHIFT: begin
               if (!phase_q) begin
                  phase_d = 1'b1;
                  shcp_d  = 1'b1;
               end else if (k_q == '0) begin
                  state_d = S_LATCH;
                  shcp_d  = 1'b0;
                  stcp_d  = 1'b1;
                  rows_d  = ROWS'(1) << row_q;
               end else begin
                  k_d     = k_q - 1'b1;
                  phase_d = 1'b0;
                  shcp_d  = 1'b0;
                  ds_d    = pix_bit(snap_q, row_q, k_q - 1'b1, plane_q);
               end
            end
            S_LATCH: begin
               state_d = S_DISPLAY;
               stcp_d  = 1'b0;
               oe_n_d  = 1'b0;
               on_d    = ON_W'(ON_TICKS - 1);
            end
            S_DISPLAY: begin
               if (on_q != '0) begin
                  on_d = on_q - 1'b1;
               end else begin
                  oe_n_d  = 1'b1;
                  row_d   = row_nx;
                  plane_d = plane_nx;
                  fd_d    = last_row && last_plane;
                  if (!bus.en) begin
                     state_d = S_IDLE;
                     rows_d  = '0;
                     ds_d    = 1'b0;
                  end else if (last_row && last_plane) begin
                     state_d = S_CLEAR;
                     mr_n_d  = 1'b0;
                     ds_d    = 1'b0;
                     snap_d  = bus.pixels;
                     row_d   = '0;
                     plane_d = BPP'(1);
                  end else begin
                     state_d = S_SHIFT;
                     k_d     = K_W'(N - 1);
                     phase_d = 1'b0;
                     shcp_d  = 1'b0;
                     ds_d    = pix_bit(snap_q, row_nx, K_W'(N - 1), plane_nx);
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         row_q   <= '0;
         plane_q <= BPP'(1);
         k_q     <= '0;
         phase_q <= 1'b0;
         on_q    <= '0;
         snap_q  <= '0;
         rows_q  <= '0;
         ds_q    <= 1'b0;
         shcp_q  <= 1'b0;
         stcp_q  <= 1'b0;
         mr_n_q  <= 1'b0;
         oe_n_q  <= 1'b1;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         row_q   <= row_d;
         plane_q <= plane_d;
         k_q     <= k_d;
         phase_q <= phase_d;
         on_q    <= on_d;
         snap_q  <= snap_d;
         rows_q  <= rows_d;
         ds_q    <= ds_d;
         shcp_q  <= shcp_d;
         stcp_q  <= stcp_d;
         mr_n_q  <= mr_n_d;
         oe_n_q  <= oe_n_d;
         fd_q    <= fd_d;
      end
   end

   assign bus.rows_out   = rows_q;
   assign bus.ds         = ds_q;
   assign bus.shcp       = shcp_q;
   assign bus.stcp       = stcp_q;
   assign bus.mr_n       = mr_n_q;
   assign bus.oe_n       = oe_n_q;
   assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_led_matrix_scanner.sv
module tb_led_matrix_scanner;
   localparam int ROWS = 2, COLS = 2, CH = 2, BPP = 2, ON = 4;
   localparam int LEVELS = (1 << BPP) - 1;
   localparam int N = COLS * CH;
   localparam int FRAME_TICKS = 1 + ROWS * LEVELS * (2 * N + 1 + ON);
   localparam int PW = ROWS * COLS * CH * BPP;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n_a, rst_n_b;
   led_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS), .CHANNELS(CH), .BPP(BPP)) bus_a();
   led_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS), .CHANNELS(CH), .BPP(BPP)) bus_b();

   led_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .CHANNELS(CH), .BPP(BPP),
                        .DIV(1), .ON_TICKS(ON)) u_dut_a (
      .clk(clk), .rst_n(rst_n_a), .bus(bus_a.master));
   led_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .CHANNELS(CH), .BPP(BPP),
                        .DIV(4), .ON_TICKS(ON)) u_dut_b (
      .clk(clk), .rst_n(rst_n_b), .bus(bus_b.master));

   int n_cmp = 0, n_bad = 0, cyc = 0;
   int pix_m [ROWS][COLS][CH];
   int pix_at_edge [ROWS][COLS][CH];
   int snap_m [ROWS][COLS][CH];
   logic shcp_prev = 1'b0;
   int last_fd = 0;
   bit have_fd = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive_pixels();
      logic [PW-1:0] v;
      v = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            for (int ch = 0; ch < CH; ch++)
               v[((r * CH + ch) * COLS + c) * BPP +: BPP] = BPP'(pix_m[r][c][ch]);
      bus_a.pixels = v;
   endtask

   task automatic set_random();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            for (int ch = 0; ch < CH; ch++)
               pix_m[r][c][ch] = int'($urandom_range(0, LEVELS));
      drive_pixels();
   endtask

   task automatic set_single();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            for (int ch = 0; ch < CH; ch++)
               pix_m[r][c][ch] = 0;
      pix_m[0][1][0] = 2;
      drive_pixels();
   endtask

   task automatic step();
      shcp_prev   = bus_a.shcp;
      pix_at_edge = pix_m;
      @(negedge clk);
      cyc++;
      if (cyc > 30000) begin
         $display("FAIL timeout: cycle %0d exceeded budget 30000", cyc);
         $fatal(1, "cycle budget exhausted");
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_val({pfx, "_rows"}, bus_a.rows_out, 0);
      check_val({pfx, "_ds"}, bus_a.ds, 0);
      check_val({pfx, "_shcp"}, bus_a.shcp, 0);
      check_val({pfx, "_stcp"}, bus_a.stcp, 0);
      check_val({pfx, "_mr_n"}, bus_a.mr_n, 0);
      check_val({pfx, "_oe_n"}, bus_a.oe_n, 1);
      check_val({pfx, "_fd"}, bus_a.frame_done, 0);
   endtask

   // Follows one frame from CLEAR; returns early when en was dropped.
   task automatic run_frame(input bit scramble, input bit drop);
      int guard, nb, oe_bad, lowc, rbad;
      logic [N-1:0] got, exp;
      logic [ROWS-1:0] row_hold;
      guard = 0;
      while (bus_a.mr_n !== 1'b0 && guard < 200) begin step(); guard++; end
      check_val("clear_mr_n", bus_a.mr_n, 0);
      check_val("clear_oe_n", bus_a.oe_n, 1);
      snap_m = pix_at_edge;
      for (int r = 0; r < ROWS; r++) begin
         for (int p = 1; p <= LEVELS; p++) begin
            got = '0; nb = 0; oe_bad = 0; guard = 0;
            do begin
               step(); guard++;
               if (bus_a.shcp === 1'b1 && shcp_prev === 1'b0) begin
                  if (nb < N) got[N - 1 - nb] = bus_a.ds;
                  nb++;
                  if (scramble && r == 0 && p == 2 && nb == 2) set_random();
                  if (drop && r == 1 && p == 1 && nb == 1) bus_a.en = 1'b0;
               end
               if (bus_a.oe_n !== 1'b1) oe_bad++;
            end while (bus_a.stcp !== 1'b1 && guard < 100);
            for (int k = 0; k < N; k++)
               exp[k] = (snap_m[r][k % COLS][k / COLS] >= p);
            check_val($sformatf("shcp_edges r%0d p%0d", r, p), nb, N);
            check_val($sformatf("bits r%0d p%0d", r, p), got, exp);
            check_val($sformatf("blank_shift r%0d p%0d", r, p), oe_bad, 0);
            check_val($sformatf("row_sel r%0d p%0d", r, p), bus_a.rows_out, 64'(1) << r);
            row_hold = bus_a.rows_out;
            guard = 0;
            do begin step(); guard++; end while (bus_a.oe_n !== 1'b0 && guard < 10);
            lowc = 0; rbad = 0;
            while (bus_a.oe_n === 1'b0 && lowc < 50) begin
               lowc++;
               if (bus_a.rows_out !== row_hold) rbad++;
               step();
            end
            check_val($sformatf("on_window r%0d p%0d", r, p), lowc, ON);
            check_val($sformatf("row_hold r%0d p%0d", r, p), rbad, 0);
            check_val($sformatf("frame_done r%0d p%0d", r, p), bus_a.frame_done,
                      (r == ROWS - 1 && p == LEVELS));
            if (bus_a.frame_done === 1'b1) begin
               if (have_fd) check_val("frame_period", cyc - last_fd, FRAME_TICKS);
               last_fd = cyc; have_fd = 1;
            end
            if (drop && bus_a.en == 1'b0) begin
               check_val("drop_rows", bus_a.rows_out, 0);
               check_val("drop_oe_n", bus_a.oe_n, 1);
               have_fd = 0;
               return;
            end
         end
      end
   endtask

   // DIV=4 instance: output spacing and frame period observed continuously.
   int cyc_b = 0, last_tr_b = 0, viol_b = 0, fd_last_b = 0, n_int_b = 0, bad_int_b = 0;
   bit started_b = 0, have_fd_b = 0;
   logic [ROWS+4:0] sig_b, sig_prev_b;
   always @(negedge clk) begin
      cyc_b++;
      sig_b = {bus_b.rows_out, bus_b.ds, bus_b.shcp, bus_b.stcp, bus_b.mr_n, bus_b.oe_n};
      if (rst_n_b) begin
         if (!started_b && bus_b.mr_n === 1'b0 && sig_prev_b[1] === 1'b1) begin
            started_b = 1; last_tr_b = cyc_b;
         end else if (started_b && sig_b !== sig_prev_b) begin
            if ((cyc_b - last_tr_b) % 4 != 0) viol_b++;
            last_tr_b = cyc_b;
         end
         if (bus_b.frame_done === 1'b1) begin
            if (have_fd_b) begin
               n_int_b++;
               if (cyc_b - fd_last_b != 4 * FRAME_TICKS) bad_int_b++;
            end
            fd_last_b = cyc_b; have_fd_b = 1;
         end
      end
      sig_prev_b = sig_b;
   end

   initial begin
      int rises, bad_mr, bad_oe, bad_rows;
      rst_n_a = 1'b0; rst_n_b = 1'b0;
      bus_a.en = 1'b0; bus_a.pixels = '0;
      bus_b.en = 1'b0; bus_b.pixels = PW'($urandom);
      repeat (3) step();
      check_reset_outputs("reset");
      rst_n_a = 1'b1; rst_n_b = 1'b1; bus_b.en = 1'b1;

      rises = 0; bad_mr = 0; bad_oe = 0; bad_rows = 0;
      repeat (20) begin
         step();
         if (bus_a.shcp === 1'b1 && shcp_prev === 1'b0) rises++;
         if (bus_a.mr_n !== 1'b1) bad_mr++;
         if (bus_a.oe_n !== 1'b1) bad_oe++;
         if (bus_a.rows_out !== '0) bad_rows++;
      end
      check_val("idle_shcp_edges", rises, 0);
      check_val("idle_mr_n", bad_mr, 0);
      check_val("idle_oe_n", bad_oe, 0);
      check_val("idle_rows", bad_rows, 0);

      set_single();
      bus_a.en = 1'b1;
      run_frame(0, 0);
      set_random();
      run_frame(0, 0);
      run_frame(1, 0);
      run_frame(0, 0);
      run_frame(0, 1);

      rises = 0; bad_mr = 0; bad_oe = 0; bad_rows = 0;
      repeat (30) begin
         step();
         if (bus_a.shcp === 1'b1 && shcp_prev === 1'b0) rises++;
         if (bus_a.mr_n !== 1'b1) bad_mr++;
         if (bus_a.oe_n !== 1'b1) bad_oe++;
         if (bus_a.rows_out !== '0) bad_rows++;
      end
      check_val("stop_shcp_edges", rises, 0);
      check_val("stop_mr_n", bad_mr, 0);
      check_val("stop_oe_n", bad_oe, 0);
      check_val("stop_rows", bad_rows, 0);

      set_random();
      bus_a.en = 1'b1;
      begin
         int guard;
         guard = 0;
         while (bus_a.oe_n !== 1'b0 && guard < 200) begin step(); guard++; end
      end
      check_val("pre_reset_oe_low", bus_a.oe_n, 0);
      step(); step();
      rst_n_a = 1'b0;
      step();
      check_reset_outputs("mid_reset");
      rst_n_a = 1'b1;
      step();
      check_val("restart_clear", bus_a.mr_n, 0);
      have_fd = 0;
      run_frame(0, 0);
      set_random();
      run_frame(0, 0);

      while (cyc < 1400) step();
      check_val("b_spacing_violations", viol_b, 0);
      check_val("b_period_bad", bad_int_b, 0);
      check_val("b_enough_frames", (n_int_b >= 2), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
